// File: rtl/fixed_ascii_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the fixed-point
// to ASCII formatter.
package fixed_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest width able to hold values 0..value-1.
  function automatic int clog2_fn(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One double-dabble correction step for a single BCD digit: add 3 when the
// digit is 5 or more, so the following left shift carries correctly.
module bcd_digit_step (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    if (digit >= 4'd5) adjusted = digit + 4'd3;
    else               adjusted = digit;
  end

endmodule

// File: rtl/fixed_to_ascii_seq.sv
// Sequential signed fixed-point to ASCII formatter using one-bit-per-cycle
// double-dabble. Optional macro LEADING_BLANK_EN blanks leading integer zeros.
module fixed_to_ascii_seq
  import fixed_ascii_pkg::*;
#(
  parameter int IN_W        = 64,
  parameter int INT_DIGITS  = 6,
  parameter int FRAC_DIGITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               sign_char,
  output logic [8*INT_DIGITS-1:0]  int_ascii,
  output logic [8*FRAC_DIGITS-1:0] frac_ascii,
  output logic                     overflow
);

  localparam int N     = INT_DIGITS + FRAC_DIGITS;
  localparam int CNT_W = clog2_fn(IN_W + 1);

  state_t                  state;
  logic                    neg;
  logic [IN_W-1:0]         mag;
  logic [4*N-1:0]          bcd;
  logic                    ovf;
  logic [CNT_W-1:0]        cnt;

  logic [4*N-1:0]          bcd_adj;
  logic [4*N-1:0]          bcd_next;
  logic [IN_W-1:0]         mag_next;
  logic                    ovf_next;

  logic [7:0]              sign_fmt;
  logic [8*INT_DIGITS-1:0] int_fmt;
  logic [8*FRAC_DIGITS-1:0] frac_fmt;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_digit
      bcd_digit_step u_step (
        .digit    (bcd[4*g +: 4]),
        .adjusted (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // A bit leaving the top digit means the magnitude reached 10^N at some point.
  assign bcd_next = {bcd_adj[4*N-2:0], mag[IN_W-1]};
  assign mag_next = {mag[IN_W-2:0], 1'b0};
  assign ovf_next = ovf | bcd_adj[4*N-1];

`ifdef LEADING_BLANK_EN
  int   lead;
  logic found;
`endif

  // Formatted view of the post-shift digits, captured on entry to DONE.
  always_comb begin
    sign_fmt = neg ? ASCII_MINUS : ASCII_PLUS;
    for (int i = 0; i < FRAC_DIGITS; i++)
      frac_fmt[8*i +: 8] = ASCII_ZERO + {4'h0, bcd_next[4*i +: 4]};
    for (int j = 0; j < INT_DIGITS; j++)
      int_fmt[8*j +: 8] = ASCII_ZERO + {4'h0, bcd_next[4*(FRAC_DIGITS+j) +: 4]};
`ifdef LEADING_BLANK_EN
    lead  = 0;
    found = 1'b0;
    for (int j = INT_DIGITS - 1; j >= 0; j--) begin
      if (!found && (j == 0 || bcd_next[4*(FRAC_DIGITS+j) +: 4] != 4'd0)) begin
        lead  = j;
        found = 1'b1;
      end
    end
    for (int j = 0; j < INT_DIGITS; j++)
      if (j > lead) int_fmt[8*j +: 8] = ASCII_SPACE;
    sign_fmt = ASCII_SPACE;
    // The minus sits just left of the first printed digit, or in sign_char if no room.
    if (neg) begin
      if (lead == INT_DIGITS - 1) sign_fmt = ASCII_MINUS;
      else                        int_fmt[8*(lead+1) +: 8] = ASCII_MINUS;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      sign_char  <= ASCII_PLUS;
      int_ascii  <= {INT_DIGITS{ASCII_ZERO}};
      frac_ascii <= {FRAC_DIGITS{ASCII_ZERO}};
      neg        <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      ovf        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            neg      <= in_value[IN_W-1];
            mag      <= in_value[IN_W-1] ? (~in_value + 1'b1) : in_value;
            bcd      <= '0;
            ovf      <= 1'b0;
            cnt      <= CNT_W'(IN_W);
            in_ready <= 1'b0;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd <= bcd_next;
          mag <= mag_next;
          ovf <= ovf_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            overflow   <= ovf_next;
            sign_char  <= sign_fmt;
            int_ascii  <= int_fmt;
            frac_ascii <= frac_fmt;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_ascii_seq.sv
// Self-checking bench for fixed_to_ascii_seq: directed, randomised, stall,
// back-to-back, mid-conversion reset and an 8-bit-wide instance.
module tb_fixed_to_ascii_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid, overflow;
  logic [63:0] in_value;
  logic [7:0]  sign_char;
  logic [47:0] int_ascii, frac_ascii;

  logic        in_valid8, out_ready8;
  logic        in_ready8, out_valid8, overflow8;
  logic [7:0]  in_value8;
  logic [7:0]  sign_char8;
  logic [47:0] int_ascii8, frac_ascii8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_to_ascii_seq #(.IN_W(64), .INT_DIGITS(6), .FRAC_DIGITS(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_char(sign_char), .int_ascii(int_ascii), .frac_ascii(frac_ascii),
    .overflow(overflow)
  );

  fixed_to_ascii_seq #(.IN_W(8), .INT_DIGITS(6), .FRAC_DIGITS(6)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_value(in_value8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sign_char(sign_char8), .int_ascii(int_ascii8), .frac_ascii(frac_ascii8),
    .overflow(overflow8)
  );

  // Reference: decimal digits of |v| via plain integer arithmetic.
  function automatic void model(input logic [63:0] v, output logic [7:0] s,
                                output logic [47:0] ia, output logic [47:0] fa,
                                output logic ov);
    longint unsigned m, low;
    m   = v[63] ? (64'd0 - v) : v;
    ov  = (m >= 64'd1000000000000);
    low = m % 64'd1000000000000;
    for (int i = 0; i < 6; i++) begin
      fa[8*i +: 8] = 8'h30 + 8'(low % 10);
      low = low / 10;
    end
    for (int i = 0; i < 6; i++) begin
      ia[8*i +: 8] = 8'h30 + 8'(low % 10);
      low = low / 10;
    end
    s = v[63] ? 8'h2D : 8'h2B;
  endfunction

  // Handshake a value into the wide DUT and wait for its result.
  task automatic do_convert(input logic [63:0] v, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin errors++; $display("[TB] FAIL in_ready_wait got 0 exp 1"); end
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic check_result(input string name, input logic [63:0] v);
    logic [7:0]  s;
    logic [47:0] ia, fa;
    logic        ov;
    model(v, s, ia, fa, ov);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s out_valid got %b exp 1", name, out_valid); end
    checks++;
    if (overflow !== ov) begin errors++; $display("[TB] FAIL %s overflow got %b exp %b", name, overflow, ov); end
    checks++;
    if (sign_char !== s) begin errors++; $display("[TB] FAIL %s sign got %h exp %h", name, sign_char, s); end
    if (!ov) begin
      checks++;
      if (int_ascii !== ia || frac_ascii !== fa) begin
        errors++;
        $display("[TB] FAIL %s digits got %s.%s exp %s.%s", name, int_ascii, frac_ascii, ia, fa);
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0 || sign_char !== 8'h2B ||
        int_ascii !== 48'h303030303030 || frac_ascii !== 48'h303030303030) begin
      errors++;
      $display("[TB] FAIL reset_state got rdy=%b vld=%b ovf=%b sign=%h int=%h frac=%h",
               in_ready, out_valid, overflow, sign_char, int_ascii, frac_ascii);
    end
  endtask

  task automatic test_directed();
    logic [63:0] vals [6];
    int lat;
    vals[0] = 64'd123456789012;
    vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vals[2] = 64'd0;
    vals[3] = 64'd1000000000000;
    vals[4] = 64'd999999999999;
    vals[5] = 64'h8000_0000_0000_0000;
    for (int k = 0; k < 6; k++) begin
      do_convert(vals[k], lat);
      checks++;
      if (lat != 64) begin errors++; $display("[TB] FAIL latency_%0d got %0d exp 64", k, lat); end
      check_result("directed", vals[k]);
      release_out();
    end
  endtask

  task automatic test_random();
    logic [63:0] v;
    int lat;
    for (int k = 0; k < 25; k++) begin
      if (k % 3 == 0) v = {$urandom, $urandom};
      else begin
        v = {$urandom, $urandom} % 64'd1000000000000;
        if ($urandom_range(0, 1) == 1) v = 64'd0 - v;
      end
      do_convert(v, lat);
      check_result("random", v);
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [7:0]  s0;
    logic [47:0] i0, f0;
    logic        o0;
    int lat;
    do_convert(-64'sd42000000, lat);
    check_result("stall_first", -64'sd42000000);
    s0 = sign_char; i0 = int_ascii; f0 = frac_ascii; o0 = overflow;
    in_valid = 1'b1;
    in_value = 64'd555555555555;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sign_char !== s0 ||
          int_ascii !== i0 || frac_ascii !== f0 || overflow !== o0) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d got vld=%b rdy=%b int=%h exp held %h",
                 c, out_valid, in_ready, int_ascii, i0);
      end
    end
    in_valid = 1'b0;
    release_out();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_ignored got vld=%b rdy=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    int lat;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = {$urandom, $urandom} % 64'd1000000000000;
      do_convert(v, lat);
      check_result("b2b", v);
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_return got rdy=%b vld=%b exp 1/0", in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    int lat;
    do_convert(64'd987654321098, lat);
    check_result("pre_reset", 64'd987654321098);
    release_out();
    in_valid = 1'b1;
    in_value = 64'd111111111111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sign_char !== 8'h2B ||
        int_ascii !== 48'h303030303030 || frac_ascii !== 48'h303030303030) begin
      errors++;
      $display("[TB] FAIL reset_mid got rdy=%b vld=%b int=%h frac=%h",
               in_ready, out_valid, int_ascii, frac_ascii);
    end
    repeat (70) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_abort got vld=%b exp 0", out_valid); end
  endtask

  task automatic test_narrow();
    logic [7:0]  vals [4];
    logic [7:0]  s;
    logic [47:0] ia, fa;
    logic        ov;
    int lat;
    vals[0] = 8'h80;
    vals[1] = 8'h7F;
    vals[2] = 8'($urandom);
    vals[3] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      model({{56{vals[k][7]}}, vals[k]}, s, ia, fa, ov);
      in_valid8 = 1'b1;
      in_value8 = vals[k];
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != 8) begin errors++; $display("[TB] FAIL narrow_latency got %0d exp 8", lat); end
      checks++;
      if (sign_char8 !== s || int_ascii8 !== ia || frac_ascii8 !== fa || overflow8 !== ov) begin
        errors++;
        $display("[TB] FAIL narrow_%h got %h %s.%s ovf=%b exp %h %s.%s ovf=%b", vals[k],
                 sign_char8, int_ascii8, frac_ascii8, overflow8, s, ia, fa, ov);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_value   = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    in_value8  = '0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid_conv();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
